// File: rtl/weight_buffer_ctrl.sv
// weight_buffer_ctrl
//   Sequences the ping-pong weight buffer across a multi-layer butterfly job.
//   A fill FSM issues one DDR read burst per layer into banks A/B alternately
//   and counts the beats landing in the buffer. A compute FSM raises
//   butterfly_start once the current bank is full and frees it on bu_done.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cfg_vld/cfg_rdy              job descriptor handshake (ready only when idle)
//   cfg_base_addr                DDR byte address of layer 0 weights
//   cfg_layer_stride             byte offset between consecutive layers
//   cfg_length                   words per layer
//   cfg_num_layers               layer count
//   dma_req_vld/dma_req_rdy      read-burst request handshake
//   dma_req_addr, dma_req_beats  burst start address and length in beats
//   wbuf_up_vld                  one beat written into the buffer
//   length                       latched cfg_length for weight_buffer
//   butterfly_start              one-cycle start pulse for a full bank
//   bu_done                      compute finished the current bank
//   busy, done                   job in progress / one-cycle job-complete pulse
//   err                          sticky error flag
module weight_buffer_ctrl #(
  parameter int unsigned NUM_RAMS   = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BEAT_BYTES = 32,
  parameter int unsigned MAX_LENGTH = 16384
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_vld,
  output logic                  cfg_rdy,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_layer_stride,
  input  logic [15:0]           cfg_length,
  input  logic [15:0]           cfg_num_layers,
  output logic                  dma_req_vld,
  input  logic                  dma_req_rdy,
  output logic [ADDR_WIDTH-1:0] dma_req_addr,
  output logic [15:0]           dma_req_beats,
  input  logic                  wbuf_up_vld,
  output logic [15:0]           length,
  output logic                  butterfly_start,
  input  logic                  bu_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned BEAT_SHIFT = $clog2(NUM_RAMS);

  // A beat must hold a whole number of weight words.
  if (NUM_RAMS == 0 || (BEAT_BYTES % NUM_RAMS) != 0) begin : g_bad_geometry
    $error("BEAT_BYTES must be a non-zero multiple of NUM_RAMS");
  end

  typedef enum logic [2:0] {F_IDLE, F_REQ, F_RECV, F_WAIT, F_DONE} fill_state_t;
  typedef enum logic       {C_IDLE, C_RUN} cmp_state_t;

  fill_state_t fill_state, fill_next;
  cmp_state_t  cmp_state, cmp_next;

  logic [ADDR_WIDTH-1:0] stride;
  logic [15:0]           num_layers;
  logic [15:0]           fill_layer;
  logic [15:0]           cmp_layer;
  logic [15:0]           beat_cnt;
  logic [1:0]            full;
  logic                  fill_ptr;
  logic                  cmp_ptr;

  logic       accept, cfg_ok, start_job;
  logic       last_beat, bu_hit, job_end, cmp_start;
  logic       stray_beat, stray_done;
  logic [1:0] full_clr, full_set, full_free;

  assign cfg_rdy     = ~busy;
  assign dma_req_vld = (fill_state == F_REQ);

  assign accept = cfg_vld & cfg_rdy;
  assign cfg_ok = (cfg_length != '0)
               && ((cfg_length & (cfg_length - 16'd1)) == '0)
               && (32'(cfg_length) >= 2 * NUM_RAMS)
               && (32'(cfg_length) <= MAX_LENGTH)
               && (cfg_num_layers != '0);
  assign start_job = accept & cfg_ok;

  assign last_beat  = (fill_state == F_RECV) && wbuf_up_vld
                   && (beat_cnt == dma_req_beats - 16'd1);
  assign bu_hit     = (cmp_state == C_RUN) && bu_done;
  assign job_end    = bu_hit && (cmp_layer + 16'd1 == num_layers);
  assign cmp_start  = (cmp_state == C_IDLE) && busy && full[cmp_ptr];
  assign stray_beat = wbuf_up_vld && (fill_state != F_RECV);
  assign stray_done = bu_done && (cmp_state != C_RUN);

  always_comb begin
    full_clr = '0;
    full_set = '0;
    if (bu_hit)    full_clr[cmp_ptr]  = 1'b1;
    if (last_beat) full_set[fill_ptr] = 1'b1;
  end

  // A bank freed by bu_done this cycle is already seen as empty by the fill
  // side, so a waiting request goes out on the very next cycle.
  assign full_free = full & ~full_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_state <= F_IDLE;
      cmp_state  <= C_IDLE;
    end else begin
      fill_state <= fill_next;
      cmp_state  <= cmp_next;
    end
  end

  always_comb begin
    fill_next = fill_state;
    unique case (fill_state)
      F_IDLE: if (start_job) fill_next = F_REQ;
      F_REQ:  if (dma_req_rdy) fill_next = F_RECV;
      F_RECV: begin
        if (last_beat) begin
          if (fill_layer + 16'd1 == num_layers) fill_next = F_DONE;
          else if (full_free[~fill_ptr])        fill_next = F_WAIT;
          else                                  fill_next = F_REQ;
        end
      end
      F_WAIT: if (!full_free[fill_ptr]) fill_next = F_REQ;
      F_DONE: fill_next = F_DONE;
      default: fill_next = F_IDLE;
    endcase
    if (job_end) fill_next = F_IDLE;
  end

  always_comb begin
    cmp_next = cmp_state;
    unique case (cmp_state)
      C_IDLE:  if (cmp_start) cmp_next = C_RUN;
      C_RUN:   if (bu_hit) cmp_next = C_IDLE;
      default: cmp_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dma_req_addr    <= '0;
      dma_req_beats   <= '0;
      length          <= '0;
      stride          <= '0;
      num_layers      <= '0;
      fill_layer      <= '0;
      cmp_layer       <= '0;
      beat_cnt        <= '0;
      full            <= '0;
      fill_ptr        <= 1'b0;
      cmp_ptr         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      butterfly_start <= 1'b0;
      err             <= 1'b0;
    end else begin
      butterfly_start <= cmp_start;
      done            <= job_end;
      err             <= (accept ? ~cfg_ok : err) | stray_beat | stray_done;

      if (fill_state == F_REQ && dma_req_rdy)
        beat_cnt <= '0;
      else if (fill_state == F_RECV && wbuf_up_vld)
        beat_cnt <= beat_cnt + 16'd1;

      if (accept) begin
        length        <= cfg_length;
        num_layers    <= cfg_num_layers;
        stride        <= cfg_layer_stride;
        dma_req_addr  <= cfg_base_addr;
        dma_req_beats <= cfg_length >> BEAT_SHIFT;
      end

      if (start_job || job_end) begin
        busy       <= start_job;
        full       <= '0;
        fill_ptr   <= 1'b0;
        cmp_ptr    <= 1'b0;
        fill_layer <= '0;
        cmp_layer  <= '0;
      end else begin
        full <= full_free | full_set;
        if (last_beat) begin
          fill_ptr     <= ~fill_ptr;
          fill_layer   <= fill_layer + 16'd1;
          dma_req_addr <= dma_req_addr + stride;
        end
        if (bu_hit) begin
          cmp_ptr   <= ~cmp_ptr;
          cmp_layer <= cmp_layer + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
module tb_weight_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_vld;
  logic        cfg_rdy;
  logic [31:0] cfg_base_addr;
  logic [31:0] cfg_layer_stride;
  logic [15:0] cfg_length;
  logic [15:0] cfg_num_layers;
  logic        dma_req_vld;
  logic        dma_req_rdy;
  logic [31:0] dma_req_addr;
  logic [15:0] dma_req_beats;
  logic        wbuf_up_vld;
  logic [15:0] length;
  logic        butterfly_start;
  logic        bu_done;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  // {cfg_rdy, dma_req_vld, busy, butterfly_start, done, err}
  logic [5:0] st;
  assign st = {cfg_rdy, dma_req_vld, busy, butterfly_start, done, err};

  weight_buffer_ctrl #(
    .NUM_RAMS(16),
    .ADDR_WIDTH(32),
    .BEAT_BYTES(32),
    .MAX_LENGTH(16384)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
    .cfg_base_addr(cfg_base_addr), .cfg_layer_stride(cfg_layer_stride),
    .cfg_length(cfg_length), .cfg_num_layers(cfg_num_layers),
    .dma_req_vld(dma_req_vld), .dma_req_rdy(dma_req_rdy),
    .dma_req_addr(dma_req_addr), .dma_req_beats(dma_req_beats),
    .wbuf_up_vld(wbuf_up_vld), .length(length),
    .butterfly_start(butterfly_start), .bu_done(bu_done),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
  endtask

  task automatic give_cfg(input logic [31:0] base, input logic [31:0] strd,
                          input logic [15:0] len, input logic [15:0] layers);
    cfg_base_addr = base; cfg_layer_stride = strd;
    cfg_length = len; cfg_num_layers = layers;
    cfg_vld = 1'b1; cyc(); cfg_vld = 1'b0;
  endtask

  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) begin
      wbuf_up_vld = 1'b1; cyc();
    end
    wbuf_up_vld = 1'b0;
  endtask

  task automatic pulse_bu_done();
    bu_done = 1'b1; cyc(); bu_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (st !== 6'b100000) begin n_bad++; $display("FAIL reset_status got=%b want=%b", st, 6'b100000); end
    n_cmp++; if ({dma_req_addr, dma_req_beats, length} !== 64'h0) begin n_bad++;
      $display("FAIL reset_regs got addr=%h beats=%0d len=%0d want 0/0/0", dma_req_addr, dma_req_beats, length); end
  endtask

  task automatic test_single_layer();
    dma_req_rdy = 1'b1;
    give_cfg(32'h1000, 32'h0, 16'd256, 16'd1);
    n_cmp++; if (st !== 6'b011000) begin n_bad++; $display("FAIL t1_accept got=%b want=%b", st, 6'b011000); end
    n_cmp++; if (dma_req_addr !== 32'h1000 || dma_req_beats !== 16'd16 || length !== 16'd256) begin n_bad++;
      $display("FAIL t1_req got addr=%h beats=%0d len=%0d want 1000/16/256", dma_req_addr, dma_req_beats, length); end
    cyc();
    n_cmp++; if (st !== 6'b001000) begin n_bad++; $display("FAIL t1_req_taken got=%b want=%b", st, 6'b001000); end
    send_beats(16);
    n_cmp++; if (st !== 6'b001000) begin n_bad++; $display("FAIL t1_last_beat got=%b want=%b", st, 6'b001000); end
    cyc();
    n_cmp++; if (st !== 6'b001100) begin n_bad++; $display("FAIL t1_start got=%b want=%b", st, 6'b001100); end
    cyc();
    n_cmp++; if (st !== 6'b001000) begin n_bad++; $display("FAIL t1_start_end got=%b want=%b", st, 6'b001000); end
    pulse_bu_done();
    n_cmp++; if (st !== 6'b100010) begin n_bad++; $display("FAIL t1_done got=%b want=%b", st, 6'b100010); end
    cyc();
    n_cmp++; if (st !== 6'b100000) begin n_bad++; $display("FAIL t1_done_end got=%b want=%b", st, 6'b100000); end
  endtask

  task automatic test_multi_layer();
    int starts = 0;
    dma_req_rdy = 1'b1;
    give_cfg(32'h0, 32'h200, 16'd32, 16'd4);
    n_cmp++; if (st !== 6'b011000 || dma_req_addr !== 32'h0) begin n_bad++;
      $display("FAIL t2_req0 got=%b addr=%h want=011000 addr=0", st, dma_req_addr); end
    cyc();
    send_beats(2);
    n_cmp++; if (st !== 6'b011000 || dma_req_addr !== 32'h200) begin n_bad++;
      $display("FAIL t2_req1 got=%b addr=%h want=011000 addr=200", st, dma_req_addr); end
    cyc(); if (butterfly_start) starts++;
    n_cmp++; if (st !== 6'b001100) begin n_bad++; $display("FAIL t2_start_a0 got=%b want=%b", st, 6'b001100); end
    send_beats(2);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (st !== 6'b001000) begin n_bad++; $display("FAIL t2_req2_held got=%b want=%b", st, 6'b001000); end
      cyc();
    end
    pulse_bu_done();
    n_cmp++; if (st !== 6'b011000 || dma_req_addr !== 32'h400) begin n_bad++;
      $display("FAIL t2_req2 got=%b addr=%h want=011000 addr=400", st, dma_req_addr); end
    cyc(); if (butterfly_start) starts++;
    n_cmp++; if (st !== 6'b001100) begin n_bad++; $display("FAIL t2_start_b1 got=%b want=%b", st, 6'b001100); end
    send_beats(2);
    n_cmp++; if (st !== 6'b001000) begin n_bad++; $display("FAIL t2_req3_held got=%b want=%b", st, 6'b001000); end
    pulse_bu_done();
    n_cmp++; if (st !== 6'b011000 || dma_req_addr !== 32'h600) begin n_bad++;
      $display("FAIL t2_req3 got=%b addr=%h want=011000 addr=600", st, dma_req_addr); end
    cyc(); if (butterfly_start) starts++;
    n_cmp++; if (st !== 6'b001100) begin n_bad++; $display("FAIL t2_start_a2 got=%b want=%b", st, 6'b001100); end
    send_beats(2);
    n_cmp++; if (st !== 6'b001000) begin n_bad++; $display("FAIL t2_fill_done got=%b want=%b", st, 6'b001000); end
    pulse_bu_done();
    n_cmp++; if (st !== 6'b001000) begin n_bad++; $display("FAIL t2_gap got=%b want=%b", st, 6'b001000); end
    cyc(); if (butterfly_start) starts++;
    n_cmp++; if (st !== 6'b001100) begin n_bad++; $display("FAIL t2_start_b3 got=%b want=%b", st, 6'b001100); end
    cyc();
    pulse_bu_done();
    n_cmp++; if (st !== 6'b100010) begin n_bad++; $display("FAIL t2_done got=%b want=%b", st, 6'b100010); end
    n_cmp++; if (starts !== 4) begin n_bad++; $display("FAIL t2_start_count got=%0d want=4", starts); end
    cyc();
  endtask

  task automatic test_illegal_cfg();
    logic [15:0] bad_len [4] = '{16'd200, 16'd16, 16'd32768, 16'd256};
    logic [15:0] bad_lay [4] = '{16'd1,   16'd1,  16'd1,     16'd0};
    dma_req_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      give_cfg(32'h0, 32'h0, bad_len[k], bad_lay[k]);
      n_cmp++; if (st !== 6'b100001) begin n_bad++;
        $display("FAIL t3_illegal_%0d got=%b want=%b", k, st, 6'b100001); end
      cyc(); cyc();
      n_cmp++; if (st !== 6'b100001) begin n_bad++;
        $display("FAIL t3_illegal_hold_%0d got=%b want=%b", k, st, 6'b100001); end
    end
    give_cfg(32'h40, 32'h0, 16'd32, 16'd1);
    n_cmp++; if (st !== 6'b011000) begin n_bad++; $display("FAIL t3_recover got=%b want=%b", st, 6'b011000); end
    do_reset();
  endtask

  task automatic test_backpressure();
    dma_req_rdy = 1'b0;
    give_cfg(32'h3000, 32'h0, 16'd64, 16'd1);
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (st !== 6'b011000 || dma_req_addr !== 32'h3000 || dma_req_beats !== 16'd4) begin n_bad++;
        $display("FAIL t4_stable_%0d got=%b addr=%h beats=%0d want=011000 3000 4", i, st, dma_req_addr, dma_req_beats); end
      cyc();
    end
    dma_req_rdy = 1'b1; cyc();
    n_cmp++; if (st !== 6'b001000) begin n_bad++; $display("FAIL t4_accept got=%b want=%b", st, 6'b001000); end
    cyc(); cyc();
    n_cmp++; if (st !== 6'b001000) begin n_bad++; $display("FAIL t4_single got=%b want=%b", st, 6'b001000); end
    do_reset();
  endtask

  task automatic test_stray();
    wbuf_up_vld = 1'b1; cyc(); wbuf_up_vld = 1'b0;
    n_cmp++; if (st !== 6'b100001) begin n_bad++; $display("FAIL t5_stray_beat got=%b want=%b", st, 6'b100001); end
    dma_req_rdy = 1'b0;
    give_cfg(32'h0, 32'h0, 16'd32, 16'd1);
    n_cmp++; if (st !== 6'b011000) begin n_bad++; $display("FAIL t5_err_clear got=%b want=%b", st, 6'b011000); end
    pulse_bu_done();
    n_cmp++; if (st !== 6'b011001) begin n_bad++; $display("FAIL t5_stray_done got=%b want=%b", st, 6'b011001); end
    dma_req_rdy = 1'b1; cyc();
    send_beats(2);
    cyc();
    n_cmp++; if (st !== 6'b001101) begin n_bad++; $display("FAIL t5_start got=%b want=%b", st, 6'b001101); end
    cyc();
    pulse_bu_done();
    n_cmp++; if (st !== 6'b100011) begin n_bad++; $display("FAIL t5_done got=%b want=%b", st, 6'b100011); end
    do_reset();
  endtask

  task automatic test_mid_reset();
    dma_req_rdy = 1'b1;
    give_cfg(32'h100, 32'h40, 16'd32, 16'd4);
    cyc(); send_beats(2);
    cyc(); send_beats(2);
    pulse_bu_done();
    n_cmp++; if (st !== 6'b011000 || dma_req_addr !== 32'h180) begin n_bad++;
      $display("FAIL t6_req2 got=%b addr=%h want=011000 addr=180", st, dma_req_addr); end
    cyc(); send_beats(1);
    rst = 1'b1; cyc(); rst = 1'b0;
    n_cmp++; if (st !== 6'b100000 || {dma_req_addr, dma_req_beats, length} !== 64'h0) begin n_bad++;
      $display("FAIL t6_reset got=%b addr=%h beats=%0d len=%0d want 100000 0/0/0", st, dma_req_addr, dma_req_beats, length); end
    give_cfg(32'h800, 32'h40, 16'd32, 16'd2);
    n_cmp++; if (st !== 6'b011000 || dma_req_addr !== 32'h800) begin n_bad++;
      $display("FAIL t6_restart got=%b addr=%h want=011000 addr=800", st, dma_req_addr); end
    cyc(); send_beats(2);
    n_cmp++; if (st !== 6'b011000 || dma_req_addr !== 32'h840) begin n_bad++;
      $display("FAIL t6_restart_req1 got=%b addr=%h want=011000 addr=840", st, dma_req_addr); end
    cyc();
    n_cmp++; if (st !== 6'b001100) begin n_bad++; $display("FAIL t6_restart_start got=%b want=%b", st, 6'b001100); end
    do_reset();
  endtask

  initial begin
    rst = 1'b1; cfg_vld = 1'b0; cfg_base_addr = '0; cfg_layer_stride = '0;
    cfg_length = '0; cfg_num_layers = '0; dma_req_rdy = 1'b1;
    wbuf_up_vld = 1'b0; bu_done = 1'b0;
    cyc();
    test_reset();
    test_single_layer();
    test_multi_layer();
    test_illegal_cfg();
    test_backpressure();
    test_stray();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/weight_buffer_ctrl.md
Name: weight_buffer_ctrl

Overview:
- Sequences the ping-pong weight buffer across a multi-layer butterfly job.
- Issues DDR read bursts that fill banks A and B alternately, and counts the beats that arrive at the buffer.
- Raises butterfly_start to compute once a bank is full, and frees the bank when compute reports done.
- Sits between the job/config front-end, the weight DMA and weight_buffer.

Parameters:
NUM_RAMS, 16, weight words per AXI beat (DATA_WIDTH_AXI/DATA_WIDTH_BRAM)
ADDR_WIDTH, 32, DDR byte-address width
BEAT_BYTES, 32, bytes per AXI beat
MAX_LENGTH, 16384, largest legal length in words (1024-deep bank x NUM_RAMS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_vld  in  1  job descriptor valid
cfg_rdy  out  1  ready for descriptor; high only in IDLE
cfg_base_addr  in  ADDR_WIDTH  DDR address of layer 0 weights
cfg_layer_stride  in  ADDR_WIDTH  byte offset between consecutive layers
cfg_length  in  16  words per layer
cfg_num_layers  in  16  layer count, >=1
dma_req_vld  out  1  read-burst request
dma_req_rdy  in  1  DMA accepts request
dma_req_addr  out  ADDR_WIDTH  burst start address
dma_req_beats  out  16  burst length in beats = length/NUM_RAMS
wbuf_up_vld  in  1  copy of the buffer's up_vld (one beat written)
length  out  16  latched cfg_length, drives weight_buffer.length
butterfly_start  out  1  one-cycle pulse to weight_buffer and compute
bu_done  in  1  one-cycle pulse: compute finished the current bank
busy  out  1  job in progress
done  out  1  one-cycle pulse after the last bu_done
err  out  1  sticky error flag; cleared by rst or by an accepted cfg

Behaviour:
- Reset values: cfg_rdy=1, dma_req_vld=0, dma_req_addr=0, dma_req_beats=0, length=0, butterfly_start=0, busy=0, done=0, err=0. Both banks EMPTY; fill and compute pointers at bank A.
- Config acceptance (cfg_vld&cfg_rdy in IDLE):
  - Latch all cfg fields; set busy=1; clear err.
  - Illegal config: length not a power of two, length<2*NUM_RAMS, length>MAX_LENGTH, or num_layers==0.
  - On illegal config: set err=1, stay IDLE, busy stays 0, and issue no request.
- Bank state: one bit per bank, full[A], full[B].
- Fill FSM:
  - F_IDLE -> F_REQ on accept.
  - F_REQ: dma_req_vld=1 with addr=base+fill_layer*stride (accumulate by adding stride; no multiplier) and beats=length/NUM_RAMS. Hold all three stable until dma_req_rdy; then -> F_RECV.
  - F_RECV: count wbuf_up_vld. On the final beat set full[fill_ptr], toggle fill_ptr and increment fill_layer. Then:
    - all layers requested -> F_DONE;
    - else if full[next bank] -> F_WAIT;
    - else -> F_REQ.
  - F_WAIT -> F_REQ on the cycle after the target bank frees.
  - F_DONE: idle until the job ends.
- Compute FSM:
  - C_IDLE: when full[cmp_ptr], pulse butterfly_start in the next cycle -> C_RUN.
  - C_RUN: on bu_done, clear full[cmp_ptr], toggle cmp_ptr and increment cmp_layer.
    - If cmp_layer reaches num_layers: pulse done, busy=0, both FSMs -> IDLE, cfg_rdy=1.
    - Otherwise -> C_IDLE.
- Bank order is strictly A,B,A,B for both fill and compute, matching the buffer's internal toggles. Never more than one start per fill.
- Simultaneous events:
  - Last beat (sets full[x]) and bu_done on the same bank cannot legally coincide.
  - bu_done freeing bank y while fill waits on y: the free takes effect first, so the request issues the next cycle.
- Errors set err (sticky; operation continues):
  - wbuf_up_vld outside F_RECV (beat dropped from count);
  - bu_done outside C_RUN (ignored).
- Beat counter is 16-bit and resets to 0 at each F_REQ->F_RECV. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- rst mid-job: all state returns to reset values next cycle and in-flight beats are not tracked. The DMA must be reset alongside.
- Latency minima:
  - cfg accept -> dma_req_vld: 1 cycle.
  - last beat -> butterfly_start: 2 cycles when compute is idle.
  - final bu_done -> done: 1 cycle.

Test Plan:
1. cfg length=256, layers=1, base=0x1000, dma_req_rdy=1 -> one request addr=0x1000 beats=16; after 16 beats, butterfly_start 2 cycles later; bu_done -> done pulse, busy=0, cfg_rdy=1.
2. layers=4, stride=0x200, base=0, no backpressure:
   - requests at 0x0, 0x200, 0x400, 0x600;
   - third request held until the first bu_done;
   - four starts in bank order A,B,A,B.
3. Illegal configs, each applied separately, plus recovery:
   - cfg length=200 -> err=1, no dma_req_vld;
   - cfg length=16 -> err=1, no dma_req_vld;
   - valid cfg afterwards -> err clears.
4. dma_req_rdy low 10 cycles -> addr/beats stable for all 10 cycles, single acceptance.
5. Stray wbuf_up_vld while in IDLE -> err=1, no state change; stray bu_done in C_IDLE -> err=1, ignored.
6. rst asserted mid-F_RECV of layer 2 -> next cycle all outputs at reset values; a new cfg restarts at bank A.
